// File: rtl/lab1_imul_mac_pkg.sv
// Shared types and message geometry for the multiply-accumulate initiator.
// Used by lab1_imul_mac_initiator and lab1_imul_mac_tag_fifo.
package lab1_imul_mac_pkg;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int A_NBITS   = 32;
    localparam int IN_NBITS  = 65;
    localparam int REQ_NBITS = 64;
    localparam int LAST_BIT  = 64;

endpackage

// File: rtl/lab1_imul_mac_tag_fifo.sv
// One-bit tag FIFO that remembers which in-flight multiply carries the "last" mark.
// Push and pop may occur together even when full.
module lab1_imul_mac_tag_fifo #(
    parameter int p_depth = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic pop_data,
    output logic full,
    output logic empty
);
    localparam int CNT_W = $clog2(p_depth + 1);
    localparam int PTR_W = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(p_depth - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(p_depth);

    logic [p_depth-1:0] mem_reg;
    logic [p_depth-1:0] wr_en;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               push_ok;
    logic               pop_ok;

    assign full     = (count_reg == DEPTH_CNT);
    assign empty    = (count_reg == '0);
    assign pop_ok   = pop && !empty;
    // A full FIFO only takes a push when the head leaves in the same cycle.
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = mem_reg[rd_ptr_reg];

    genvar gi;
    generate
        for (gi = 0; gi < p_depth; gi++) begin : g_wr_en
            assign wr_en[gi] = push_ok && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < p_depth; i++) begin
            if (wr_en[i]) mem_reg[i] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/lab1_imul_mac_initiator.sv
// Streams operand pairs to a val/rdy multiplier and sums the returned products per "last"-terminated sequence.
// Optional macro LAB1_IMUL_MAC_INITIATOR_OVF_EN adds out_ovf, a sticky carry-out-of-bit-31 flag.
module lab1_imul_mac_initiator
    import lab1_imul_mac_pkg::*;
#(
    parameter int p_max_outstanding = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_val,
    output logic                 in_rdy,
    input  logic [IN_NBITS-1:0]  in_msg,
    output logic                 mul_req_val,
    input  logic                 mul_req_rdy,
    output logic [REQ_NBITS-1:0] mul_req_msg,
    input  logic                 mul_resp_val,
    output logic                 mul_resp_rdy,
    input  logic [A_NBITS-1:0]   mul_resp_msg,
    output logic                 out_val,
    input  logic                 out_rdy,
    output logic [A_NBITS-1:0]   out_msg
`ifdef LAB1_IMUL_MAC_INITIATOR_OVF_EN
    ,
    output logic                 out_ovf
`endif
);
    state_t             state_reg, state_next;
    logic [A_NBITS-1:0] acc_reg, acc_next;
    logic [A_NBITS-1:0] out_msg_reg, out_msg_next;
    logic [A_NBITS-1:0] sum;
    logic               can_issue;
    logic               issue_fire;
    logic               resp_fire;
    logic               tag_head;
    logic               tag_full;
    logic               tag_empty;

    // The tag FIFO occupancy doubles as the outstanding-request count.
    lab1_imul_mac_tag_fifo #(
        .p_depth (p_max_outstanding)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (issue_fire),
        .push_data (in_msg[LAST_BIT]),
        .pop       (resp_fire),
        .pop_data  (tag_head),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    assign can_issue    = (state_reg == ACC) && !tag_full;
    assign in_rdy       = mul_req_rdy && can_issue;
    assign mul_req_val  = in_val && can_issue;
    assign mul_req_msg  = in_msg[REQ_NBITS-1:0];
    assign mul_resp_rdy = (state_reg != DONE) && !tag_empty;
    assign issue_fire   = in_val && in_rdy;
    assign resp_fire    = mul_resp_val && mul_resp_rdy;
    assign out_val      = (state_reg == DONE);
    assign out_msg      = out_msg_reg;

`ifdef LAB1_IMUL_MAC_INITIATOR_OVF_EN
    logic [A_NBITS:0] sum_wide;
    logic             ovf_reg, ovf_next;
    logic             out_ovf_reg, out_ovf_next;

    assign sum_wide = {1'b0, acc_reg} + {1'b0, mul_resp_msg};
    assign sum      = sum_wide[A_NBITS-1:0];
    assign out_ovf  = out_ovf_reg;

    always_comb begin
        ovf_next     = ovf_reg;
        out_ovf_next = out_ovf_reg;
        if (resp_fire) begin
            ovf_next = ovf_reg | sum_wide[A_NBITS];
            if (tag_head) begin
                out_ovf_next = ovf_next;
                ovf_next     = 1'b0;
            end
        end
        if ((state_reg == DONE) && out_rdy) out_ovf_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_reg     <= 1'b0;
            out_ovf_reg <= 1'b0;
        end else begin
            ovf_reg     <= ovf_next;
            out_ovf_reg <= out_ovf_next;
        end
    end
`else
    assign sum = acc_reg + mul_resp_msg;
`endif

    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        out_msg_next = out_msg_reg;
        case (state_reg)
            ACC:     if (issue_fire && in_msg[LAST_BIT]) state_next = DRAIN;
            DRAIN:   state_next = DRAIN;
            DONE:    if (out_rdy) state_next = ACC;
            default: state_next = ACC;
        endcase
        // A response can only pop the last tag after that tag was pushed, so this overrides safely.
        if (resp_fire) begin
            acc_next = sum;
            if (tag_head) begin
                acc_next     = '0;
                out_msg_next = sum;
                state_next   = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ACC;
            acc_reg     <= '0;
            out_msg_reg <= '0;
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            out_msg_reg <= out_msg_next;
        end
    end

endmodule

// File: tb/tb_lab1_imul_mac_initiator.sv
// Randomized bench for lab1_imul_mac_initiator with an in-order variable-latency multiplier model
// and a sequence-level sum-of-products reference.
module tb_lab1_imul_mac_initiator;
    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_val;
    logic        in_rdy;
    logic [64:0] in_msg;
    logic        mul_req_val;
    logic        mul_req_rdy;
    logic [63:0] mul_req_msg;
    logic        mul_resp_val;
    logic        mul_resp_rdy;
    logic [31:0] mul_resp_msg;
    logic        out_val;
    logic        out_rdy;
    logic [31:0] out_msg;
`ifdef LAB1_IMUL_MAC_INITIATOR_OVF_EN
    logic        out_ovf;
`endif

    always #5 clk = ~clk;

    lab1_imul_mac_initiator #(.p_max_outstanding(MAXO)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_val       (in_val),
        .in_rdy       (in_rdy),
        .in_msg       (in_msg),
        .mul_req_val  (mul_req_val),
        .mul_req_rdy  (mul_req_rdy),
        .mul_req_msg  (mul_req_msg),
        .mul_resp_val (mul_resp_val),
        .mul_resp_rdy (mul_resp_rdy),
        .mul_resp_msg (mul_resp_msg),
        .out_val      (out_val),
        .out_rdy      (out_rdy),
        .out_msg      (out_msg)
`ifdef LAB1_IMUL_MAC_INITIATOR_OVF_EN
        ,
        .out_ovf      (out_ovf)
`endif
    );

    typedef struct {
        int          ready;
        logic [31:0] prod;
        logic        last;
    } mresp_t;

    logic [64:0] src_q[$];
    mresp_t      mq[$];
    logic [31:0] exp_q[$];
    logic        exp_ovf_q[$];
    logic [31:0] results[$];
`ifdef LAB1_IMUL_MAC_INITIATOR_OVF_EN
    logic        res_ovf[$];
`endif

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int inflight = 0;
    int last_ready = 0;
    bit blocked = 0;   // last pair of a sequence issued, result not yet taken
    bit done = 0;      // last product returned, result not yet taken
    int lat_min = 1, lat_max = 1;
    int req_prob = 100, in_prob = 100, out_prob = 100;
    int out_low_left = 0;
    logic [31:0] seq_sum = 0;
    logic        seq_ovf = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic add_pair(input logic [31:0] a, input logic [31:0] b, input bit last);
        logic [31:0] p;
        logic [32:0] w;
        p = a * b;
        w = {1'b0, seq_sum} + {1'b0, p};
        seq_ovf = seq_ovf | w[32];
        seq_sum = w[31:0];
        src_q.push_back({last, a, b});
        if (last) begin
            exp_q.push_back(seq_sum);
            exp_ovf_q.push_back(seq_ovf);
            seq_sum = 0;
            seq_ovf = 0;
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            reset = 1'b1;
            in_val = 1'b0;
            mul_resp_val = 1'b0;
            out_rdy = 1'b0;
            mul_req_rdy = 1'($urandom);
        end
        src_q.delete();
        mq.delete();
        exp_q.delete();
        exp_ovf_q.delete();
        inflight = 0;
        blocked = 0;
        done = 0;
        last_ready = 0;
        out_low_left = 0;
    endtask

    task automatic step();
        mresp_t e;
        int     lat;
        @(negedge clk);
        cyc++;
        reset = 1'b0;
        in_val = (src_q.size() > 0) && ($urandom_range(99) < in_prob);
        in_msg = (src_q.size() > 0) ? src_q[0] : {1'b0, $urandom, $urandom};
        mul_req_rdy = ($urandom_range(99) < req_prob);
        mul_resp_val = (mq.size() > 0) && (mq[0].ready <= cyc);
        mul_resp_msg = mul_resp_val ? mq[0].prod : $urandom;
        if (out_val && out_low_left > 0) begin
            out_rdy = 1'b0;
            out_low_left--;
        end else begin
            out_rdy = ($urandom_range(99) < out_prob);
        end
        #1;
        chk("in_rdy", 32'(in_rdy), 32'(mul_req_rdy && !blocked && inflight < MAXO));
        chk("mul_req_val", 32'(mul_req_val), 32'(in_val && !blocked && inflight < MAXO));
        if (mul_req_val) begin
            chk("req_msg_a", mul_req_msg[63:32], in_msg[63:32]);
            chk("req_msg_b", mul_req_msg[31:0], in_msg[31:0]);
        end
        chk("mul_resp_rdy", 32'(mul_resp_rdy), 32'(!done && inflight > 0));
        chk("out_val", 32'(out_val), 32'(done));
        if (done && exp_q.size() > 0) begin
            chk("out_msg", out_msg, exp_q[0]);
`ifdef LAB1_IMUL_MAC_INITIATOR_OVF_EN
            chk("out_ovf", 32'(out_ovf), 32'(exp_ovf_q[0]));
`endif
        end
        if (in_val && in_rdy) begin
            lat = $urandom_range(lat_max, lat_min);
            e.ready = (cyc + lat > last_ready) ? cyc + lat : last_ready;
            last_ready = e.ready;
            e.prod = src_q[0][63:32] * src_q[0][31:0];
            e.last = src_q[0][64];
            mq.push_back(e);
            void'(src_q.pop_front());
            inflight++;
            if (e.last) blocked = 1;
        end
        if (mul_resp_val && mul_resp_rdy) begin
            e = mq.pop_front();
            inflight--;
            if (e.last) done = 1;
        end
        if (out_val && out_rdy) begin
            results.push_back(out_msg);
`ifdef LAB1_IMUL_MAC_INITIATOR_OVF_EN
            res_ovf.push_back(out_ovf);
`endif
            if (exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                void'(exp_ovf_q.pop_front());
            end
            done = 0;
            blocked = 0;
        end
    endtask

    task automatic run_until_idle(input int budget);
        int k = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && k < budget) begin
            step();
            k++;
        end
        if (src_q.size() > 0 || exp_q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout cyc=%0d actual=%0d_pending required=0_pending", cyc, exp_q.size());
            do_reset(2);
        end
    endtask

    initial begin
        int len;
        int k;
        reset = 1'b1;
        in_val = 1'b0;
        in_msg = '0;
        mul_req_rdy = 1'b0;
        mul_resp_val = 1'b0;
        mul_resp_msg = '0;
        out_rdy = 1'b0;
        do_reset(3);

        step();
        chk("rst_out_msg", out_msg, 32'd0);
        chk("rst_out_val", 32'(out_val), 32'd0);

        // Single pair, 1-cycle multiplier.
        add_pair(3, 4, 1);
        run_until_idle(200);

        // Three-pair sequence with enough latency to saturate the outstanding limit.
        lat_min = 3; lat_max = 3;
        add_pair(2, 5, 0); add_pair(3, 7, 0); add_pair(10, 10, 1);
        run_until_idle(200);

        // Back-to-back sequences with the first result stalled for 3 cycles.
        lat_min = 1; lat_max = 1;
        out_low_left = 3;
        add_pair(1, 1, 1); add_pair(6, 6, 0); add_pair(2, 2, 1);
        run_until_idle(200);

        // Wrap-around, then a non-overflowing sequence.
        add_pair(32'hFFFF_FFFF, 1, 0); add_pair(2, 1, 1);
        run_until_idle(200);
        add_pair(1, 1, 1);
        run_until_idle(200);

        // Reset while draining with two products in flight.
        lat_min = 20; lat_max = 20;
        add_pair(7, 7, 0); add_pair(8, 8, 1);
        k = 0;
        while (!(blocked && inflight == 2) && k < 100) begin
            step();
            k++;
        end
        chk("drain_reached", 32'(blocked && inflight == 2), 32'd1);
        do_reset(1);
        lat_min = 1; lat_max = 1;
        add_pair(5, 5, 1);
        run_until_idle(200);

        // Random sequences under random stalls and latency.
        in_prob = 70; req_prob = 70; out_prob = 60;
        lat_min = 1; lat_max = 34;
        for (int s = 0; s < 100; s++) begin
            len = $urandom_range(8, 1);
            for (int j = 0; j < len; j++) begin
                add_pair(($urandom_range(3) == 0) ? $urandom : 32'($urandom_range(1000)),
                         $urandom, j == len - 1);
            end
        end
        run_until_idle(60000);

        chk("n_results", results.size(), 107);
        if (results.size() >= 7) begin
            chk("pin_single", results[0], 32'd12);
            chk("pin_seq131", results[1], 32'd131);
            chk("pin_b2b_1", results[2], 32'd1);
            chk("pin_b2b_40", results[3], 32'd40);
            chk("pin_wrap", results[4], 32'h0000_0001);
            chk("pin_one", results[5], 32'd1);
            chk("pin_post_rst", results[6], 32'd25);
`ifdef LAB1_IMUL_MAC_INITIATOR_OVF_EN
            chk("pin_ovf_wrap", 32'(res_ovf[4]), 32'd1);
            chk("pin_ovf_one", 32'(res_ovf[5]), 32'd0);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
